// File: rtl/io_fifo_interface.sv
`default_nettype none
// ============================================================================
//  Module   : io_fifo_interface
//  Brief    : Memory-mapped UART bridge with TX/RX FIFOs, occupancy readback
//             and sticky W1C error flags. Optional Irq via IO_FIFO_IRQ_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module io_fifo_interface #(
    parameter int          DATA_WIDTH = 8,
    parameter int          TX_DEPTH   = 8,
    parameter int          RX_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic [3:0]  IO_trans,
    input  logic        IO_recv,
    output logic [31:0] RData,
    output logic [7:0]  UartDataIn,
    output logic        UartDataInValid,
    input  logic        UartDataInReady,
    input  logic [7:0]  UartDataOut,
    input  logic        UartDataOutValid,
    output logic        UartDataOutReady
`ifdef IO_FIFO_IRQ_EN
    ,
    output logic        Irq
`endif
);

    localparam int c_tx_aw = $clog2(TX_DEPTH);
    localparam int c_rx_aw = $clog2(RX_DEPTH);
    localparam logic [c_tx_aw:0] c_tx_full_cnt = TX_DEPTH[c_tx_aw:0];
    localparam logic [c_rx_aw:0] c_rx_full_cnt = RX_DEPTH[c_rx_aw:0];
    localparam logic [29:0]      c_base_word   = BASE_ADDR[31:2];

    // ------------------------------------------------------------------
    // Address decode (word granular, Addr[1:0] ignored)
    // ------------------------------------------------------------------
    logic w_sel_status, w_sel_rxdata, w_sel_txdata, w_sel_count, w_sel_irqen;
    logic w_wr, w_rd;

    assign w_sel_status = (Addr[31:2] == c_base_word);
    assign w_sel_rxdata = (Addr[31:2] == c_base_word + 30'd1);
    assign w_sel_txdata = (Addr[31:2] == c_base_word + 30'd2);
    assign w_sel_count  = (Addr[31:2] == c_base_word + 30'd3);
    assign w_sel_irqen  = (Addr[31:2] == c_base_word + 30'd4);
    assign w_wr         = |IO_trans;
    assign w_rd         = IO_recv;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_tx_mem [TX_DEPTH];
    logic [c_tx_aw-1:0]    r_tx_wr_ptr, r_tx_rd_ptr;
    logic [c_tx_aw:0]      r_tx_count;
    logic w_tx_full, w_tx_empty, w_tx_pop, w_tx_req, w_tx_push, w_tx_ovf_set;

    assign w_tx_full    = (r_tx_count == c_tx_full_cnt);
    assign w_tx_empty   = (r_tx_count == '0);
    assign w_tx_pop     = !w_tx_empty && UartDataInReady;
    assign w_tx_req     = w_wr && w_sel_txdata && IO_trans[0];
    // A full FIFO still accepts when the head leaves on the same edge.
    assign w_tx_push    = w_tx_req && (!w_tx_full || w_tx_pop);
    assign w_tx_ovf_set = w_tx_req && !w_tx_push;

    assign UartDataInValid = !w_tx_empty;
    assign UartDataIn      = 8'(r_tx_mem[r_tx_rd_ptr]);

    always_ff @(posedge Clock) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr] <= WData[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_count  <= '0;
        end else begin
            if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + c_tx_aw'(1);
            if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + c_tx_aw'(1);
            if (w_tx_push && !w_tx_pop)
                r_tx_count <= r_tx_count + (c_tx_aw+1)'(1);
            else if (!w_tx_push && w_tx_pop)
                r_tx_count <= r_tx_count - (c_tx_aw+1)'(1);
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_rx_mem [RX_DEPTH];
    logic [c_rx_aw-1:0]    r_rx_wr_ptr, r_rx_rd_ptr;
    logic [c_rx_aw:0]      r_rx_count;
    logic w_rx_full, w_rx_empty, w_rx_push, w_rx_rd, w_rx_pop, w_rx_udf_set;

    assign w_rx_full    = (r_rx_count == c_rx_full_cnt);
    assign w_rx_empty   = (r_rx_count == '0);
    assign w_rx_push    = UartDataOutValid && !w_rx_full;
    assign w_rx_rd      = w_rd && w_sel_rxdata;
    // No bypass: a read of an empty FIFO underflows even if a byte lands now.
    assign w_rx_pop     = w_rx_rd && !w_rx_empty;
    assign w_rx_udf_set = w_rx_rd && w_rx_empty;

    assign UartDataOutReady = !w_rx_full;

    always_ff @(posedge Clock) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr] <= UartDataOut[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_count  <= '0;
        end else begin
            if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + c_rx_aw'(1);
            if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + c_rx_aw'(1);
            if (w_rx_push && !w_rx_pop)
                r_rx_count <= r_rx_count + (c_rx_aw+1)'(1);
            else if (!w_rx_push && w_rx_pop)
                r_rx_count <= r_rx_count - (c_rx_aw+1)'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: clear first, a same-edge error event wins
    // ------------------------------------------------------------------
    logic r_tx_overflow, r_rx_underflow;
    logic w_wr_clear;

    assign w_wr_clear = w_wr && w_sel_status;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_tx_overflow  <= 1'b0;
            r_rx_underflow <= 1'b0;
        end else begin
            r_tx_overflow  <= w_tx_ovf_set | (r_tx_overflow  & ~(w_wr_clear & WData[4]));
            r_rx_underflow <= w_rx_udf_set | (r_rx_underflow & ~(w_wr_clear & WData[5]));
        end
    end

    // ------------------------------------------------------------------
    // Optional interrupt
    // ------------------------------------------------------------------
    logic [31:0] w_irqen_rd;

`ifdef IO_FIFO_IRQ_EN
    logic [2:0] r_irq_en;
    logic       r_irq;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_irq_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && w_sel_irqen) r_irq_en <= WData[2:0];
            r_irq <= (r_irq_en[0] & !w_rx_empty)
                   | (r_irq_en[1] & w_tx_empty)
                   | (r_irq_en[2] & (r_tx_overflow | r_rx_underflow));
        end
    end

    assign w_irqen_rd = {29'b0, r_irq_en};
    assign Irq        = r_irq;
`else
    assign w_irqen_rd = 32'b0;
`endif

    // ------------------------------------------------------------------
    // Read mux and registered load data
    // ------------------------------------------------------------------
    logic [31:0] w_rdata;

    always_comb begin
        w_rdata = 32'b0;
        if (w_sel_status) begin
            w_rdata = {26'b0, r_rx_underflow, r_tx_overflow, w_rx_full,
                       w_tx_empty, !w_rx_empty, !w_tx_full};
        end else if (w_sel_rxdata) begin
            w_rdata = w_rx_empty ? 32'b0 : 32'(r_rx_mem[r_rx_rd_ptr]);
        end else if (w_sel_count) begin
            w_rdata = {16'(r_rx_count), 16'(r_tx_count)};
        end else if (w_sel_irqen) begin
            w_rdata = w_irqen_rd;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            RData <= 32'b0;
        end else if (w_rd) begin
            RData <= w_rdata;
        end
    end

    // Bits of the bus that this block never decodes.
    logic w_unused_bits;
    assign w_unused_bits = ^{Addr[1:0], WData, UartDataOut};

endmodule
`default_nettype wire
